driver_sout_serializer: RTL and testbench
=========================================

Name: driver_sout_serializer

Overview:
- Stage directly downstream of the LED channel-remap stage.
- Captures one remapped frame slice (15 drivers × 9 bit-planes × 48 bits) and shifts it serially into the 15 TLC-series LED driver chains, one SOUT line per driver.
- Generates SCLK enable and the LAT pulse: WRTGS-style on intermediate planes, LATGS-style on the final plane.
- Emits a frame-done strobe that the upstream stage uses for pacing.

Parameters:
- NB_DRIVERS, 15, number of driver chains / SOUT lines
- PLANE_BITS, 48, bits per plane (16 LEDs × 3 colours)
- NB_PLANES, 9, bit-planes per slice
- WRTGS_LEN, 1, LAT-high SCLK count at end of a non-final plane
- LATGS_LEN, 3, LAT-high SCLK count at end of final plane

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- data_in  in  15 × 432 (unpacked array [14:0] of [431:0])  remapped slice; bit 48*p+k is plane p, position k
- data_valid  in  1  data_in valid
- data_ready  out  1  block can accept a slice
- sout  out  NB_DRIVERS  serial data, one bit per driver
- sclk_en  out  1  gates driver SCLK; shift occurs on cycles where high
- lat  out  1  driver latch line
- busy  out  1  high from capture to end of shifting
- frame_done  out  1  one-cycle strobe after last bit of plane NB_PLANES-1

Behaviour:
- One clock domain, synchronous active-high reset. All registers clear on rst regardless of state, including mid-shift: state IDLE, sout=0, sclk_en=0, lat=0, busy=0, frame_done=0, data_ready=0 during rst and 1 the first cycle after.
- Handshake: capture on data_valid && data_ready. data_ready = (state==IDLE). data_valid while busy is ignored; no queueing.
- States:
  - IDLE: data_ready=1. On handshake, latch all 15 × 432 bits into a shadow register and go to SHIFT with plane=0, bit=47.
  - SHIFT: sclk_en=1; sout[d] = shadow[d][48*plane+bit]. Planes are sent 0..8; within a plane, MSB first (bit 47 down to 0). bit decrements each cycle. At bit==0, go to GAP.
  - GAP: one cycle; sclk_en=0, sout=0, lat=0. If plane==NB_PLANES-1, go to IDLE and pulse frame_done. Otherwise increment plane, set bit=47, return to SHIFT.
- LAT: high during SHIFT cycles with bit < WRTGS_LEN (non-final plane) or bit < LATGS_LEN (final plane). Low everywhere else.
- Latency: first sout bit is valid the cycle after the handshake.
- Frame length: NB_PLANES*(PLANE_BITS+1) = 441 cycles from first SHIFT to frame_done inclusive. data_ready re-asserts the cycle after frame_done.
- Counters: bit 6 bits wide, plane 4 bits wide, no wrap-around beyond the stated bounds. Outputs are registered.

Optional Feature:
- Macro SOUT_TEST_PATTERN_EN.
- When defined: adds input test_mode (1 bit). If test_mode=1 at capture, the shadow register loads a walking pattern instead of data_in: driver d gets a 1 only at bit index 48*(d%9) + (d%48), zeros elsewhere.
- When undefined: the port is absent and behaviour is exactly as above.

Decomposition:
- Shared package spirose_drv_pkg holds NB_DRIVERS, PLANE_BITS, NB_PLANES, WRTGS_LEN, LATGS_LEN and the state enum typedef (IDLE, SHIFT, GAP). The remap stage reuses the same width constants from it.
- One natural sub-module: sout_bit_counter, the plane/bit counter with last-bit and LAT-window decode.

Test Plan:
- Reset then slice with driver0 = 432'h1 (bit 0 of plane 0 only), others 0 → sout[0]=1 only on the 48th SHIFT cycle (first plane); frame_done at cycle 441.
- All-ones slice → sclk_en high 48 cycles, low 1, repeated 9 times. LAT high on 1 cycle per plane for planes 0–7 and on 3 cycles for plane 8.
- data_valid held high continuously → exactly one capture per 442-cycle period; data changed mid-frame never appears on sout.
- rst asserted at SHIFT plane 4, bit 20 → next cycle all outputs 0, data_ready=1; a new slice restarts at plane 0, bit 47.
- Driver 14 bit 48*8+47 =1 → sout[14] high on the first SHIFT cycle of plane 8, coincident with no LAT.
- With SOUT_TEST_PATTERN_EN and test_mode=1 → driver 3 emits a single 1 in plane 3 at bit 3; data_in is ignored.

Source files
------------

// File: rtl/spirose_drv_pkg.sv
// Shared constants and state type for the LED driver path (remap and SOUT serializer).
// The optional test-pattern load is enabled by the SOUT_TEST_PATTERN_EN macro in the serializer.
package spirose_drv_pkg;

  localparam int NB_DRIVERS = 15;
  localparam int PLANE_BITS = 48;
  localparam int NB_PLANES  = 9;
  localparam int WRTGS_LEN  = 1;
  localparam int LATGS_LEN  = 3;

  localparam int SLICE_BITS = PLANE_BITS * NB_PLANES;
  localparam int BIT_W      = 6;
  localparam int PLANE_W    = 4;
  localparam int IDX_W      = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } drv_state_t;

  // Walking-pattern bit position used by the serializer self-test load.
  function automatic int test_pattern_index(input int d);
    return PLANE_BITS * (d % NB_PLANES) + (d % PLANE_BITS);
  endfunction

endpackage

// File: rtl/driver_sout_serializer_bit_counter.sv
// Plane / bit position counter for the SOUT serializer, exposing next-position values
// so the serializer can register its outputs one cycle ahead of the position.
module sout_bit_counter
  import spirose_drv_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               dec_bit,
  input  logic               next_plane,
  output logic [PLANE_W-1:0] plane_next,
  output logic [BIT_W-1:0]   bit_next,
  output logic               last_bit,
  output logic               last_plane,
  output logic               lat_window_next
);

  localparam logic [BIT_W-1:0]   TOP_BIT    = BIT_W'(PLANE_BITS - 1);
  localparam logic [PLANE_W-1:0] LAST_PLANE = PLANE_W'(NB_PLANES - 1);

  logic [PLANE_W-1:0] plane_reg;
  logic [BIT_W-1:0]   bit_idx_reg;

  assign last_bit   = (bit_idx_reg == '0);
  assign last_plane = (plane_reg == LAST_PLANE);

  always_comb begin
    plane_next = plane_reg;
    bit_next   = bit_idx_reg;
    if (load) begin
      plane_next = '0;
      bit_next   = TOP_BIT;
    end else if (next_plane && !last_plane) begin
      plane_next = plane_reg + PLANE_W'(1);
      bit_next   = TOP_BIT;
    end else if (dec_bit && !last_bit) begin
      bit_next = bit_idx_reg - BIT_W'(1);
    end
  end

  // The final plane holds LAT for the longer LATGS window.
  always_comb begin
    if (plane_next == LAST_PLANE)
      lat_window_next = (bit_next < BIT_W'(LATGS_LEN));
    else
      lat_window_next = (bit_next < BIT_W'(WRTGS_LEN));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      plane_reg   <= '0;
      bit_idx_reg <= '0;
    end else begin
      plane_reg   <= plane_next;
      bit_idx_reg <= bit_next;
    end
  end

endmodule

// File: rtl/driver_sout_serializer.sv
// Captures a remapped 15 x 9 x 48-bit slice and shifts it MSB-first into the driver chains.
// Define SOUT_TEST_PATTERN_EN to add the test_mode input (walking-pattern load).
module driver_sout_serializer
  import spirose_drv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SLICE_BITS-1:0] data_in [NB_DRIVERS-1:0],
  input  logic                  data_valid,
`ifdef SOUT_TEST_PATTERN_EN
  input  logic                  test_mode,
`endif
  output logic                  data_ready,
  output logic [NB_DRIVERS-1:0] sout,
  output logic                  sclk_en,
  output logic                  lat,
  output logic                  busy,
  output logic                  frame_done
);

  drv_state_t state_reg, state_next;

  logic               handshake;
  logic [PLANE_W-1:0] plane_next;
  logic [BIT_W-1:0]   bit_next;
  logic               last_bit, last_plane, lat_window_next;
  logic [IDX_W-1:0]   sel_idx;

  logic [SLICE_BITS-1:0] load_data   [NB_DRIVERS];
  logic [SLICE_BITS-1:0] shadow_reg  [NB_DRIVERS];
  logic [SLICE_BITS-1:0] shadow_next [NB_DRIVERS];

  logic [NB_DRIVERS-1:0] sout_reg, sout_next;
  logic sclk_en_reg, lat_reg, busy_reg, frame_done_reg;

  assign data_ready = (state_reg == IDLE) && !rst;
  assign handshake  = data_valid && data_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (handshake) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = GAP;
      GAP:     state_next = last_plane ? IDLE : SHIFT;
      default: state_next = IDLE;
    endcase
  end

  sout_bit_counter u_bit_counter (
    .clk             (clk),
    .rst             (rst),
    .load            (handshake),
    .dec_bit         (state_reg == SHIFT),
    .next_plane      (state_reg == GAP),
    .plane_next      (plane_next),
    .bit_next        (bit_next),
    .last_bit        (last_bit),
    .last_plane      (last_plane),
    .lat_window_next (lat_window_next)
  );

  // Outputs are registered, so the bit is selected from the next position and next shadow.
  assign sel_idx = IDX_W'(plane_next) * IDX_W'(PLANE_BITS) + IDX_W'(bit_next);

  generate
    for (genvar gi = 0; gi < NB_DRIVERS; gi++) begin : g_drv
`ifdef SOUT_TEST_PATTERN_EN
      localparam logic [SLICE_BITS-1:0] PATTERN = SLICE_BITS'(1) << test_pattern_index(gi);
      assign load_data[gi] = test_mode ? PATTERN : data_in[gi];
`else
      assign load_data[gi] = data_in[gi];
`endif
      assign shadow_next[gi] = handshake ? load_data[gi] : shadow_reg[gi];
      assign sout_next[gi]   = (state_next == SHIFT) && shadow_next[gi][sel_idx];

      always_ff @(posedge clk) begin
        if (rst) shadow_reg[gi] <= '0;
        else     shadow_reg[gi] <= shadow_next[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      sout_reg       <= '0;
      sclk_en_reg    <= 1'b0;
      lat_reg        <= 1'b0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sout_reg       <= sout_next;
      sclk_en_reg    <= (state_next == SHIFT);
      lat_reg        <= (state_next == SHIFT) && lat_window_next;
      busy_reg       <= (state_next != IDLE);
      frame_done_reg <= (state_next == GAP) && (plane_next == PLANE_W'(NB_PLANES - 1));
    end
  end

  assign sout       = sout_reg;
  assign sclk_en    = sclk_en_reg;
  assign lat        = lat_reg;
  assign busy       = busy_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_driver_sout_serializer.sv
// Randomized bench for driver_sout_serializer against a frame-timeline reference model.
// Compile with SOUT_TEST_PATTERN_EN to also exercise the test_mode load.
module tb_driver_sout_serializer;
  import spirose_drv_pkg::*;

  localparam int FRAME_LEN = NB_PLANES * (PLANE_BITS + 1);

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [SLICE_BITS-1:0] din [NB_DRIVERS-1:0];
  logic                  data_valid = 1'b0;
  logic                  test_mode = 1'b0;
  logic                  data_ready;
  logic [NB_DRIVERS-1:0] sout;
  logic                  sclk_en, lat, busy, frame_done;

  always #5 clk = ~clk;

  driver_sout_serializer dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (din),
    .data_valid (data_valid),
`ifdef SOUT_TEST_PATTERN_EN
    .test_mode  (test_mode),
`endif
    .data_ready (data_ready),
    .sout       (sout),
    .sclk_en    (sclk_en),
    .lat        (lat),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // Reference model: t = 0 is idle, t = 1..FRAME_LEN counts cycles since capture.
  logic [SLICE_BITS-1:0] model_slice [NB_DRIVERS];
  int t = 0;
  int cyc = 0;
  int n_capt = 0;
  int vectors = 0;
  int miscompares = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL %s cycle=%0d t=%0d got=%h expected=%h", tag, cyc, t, obs, exp_v);
    end
  endtask

  task automatic step(input logic v, input logic r);
    logic [NB_DRIVERS-1:0] e_sout;
    logic e_sclk, e_lat, e_busy, e_fd, e_ready;
    int p, q, b;
    data_valid = v;
    rst = r;
    @(posedge clk);
    cyc++;
    if (r) begin
      t = 0;
    end else if (t == 0) begin
      if (v) begin
        for (int d = 0; d < NB_DRIVERS; d++) begin
`ifdef SOUT_TEST_PATTERN_EN
          if (test_mode) begin
            model_slice[d] = '0;
            model_slice[d][PLANE_BITS * (d % NB_PLANES) + (d % PLANE_BITS)] = 1'b1;
          end else
            model_slice[d] = din[d];
`else
          model_slice[d] = din[d];
`endif
        end
        n_capt++;
        $display("capture %0d at cycle %0d test_mode=%0b", n_capt, cyc, test_mode);
        t = 1;
      end
    end else if (t == FRAME_LEN) begin
      t = 0;
    end else begin
      t++;
    end
    #1;
    e_sout = '0; e_sclk = 0; e_lat = 0; e_busy = 0; e_fd = 0;
    e_ready = (t == 0) && !rst;
    if (t != 0) begin
      e_busy = 1;
      p = (t - 1) / (PLANE_BITS + 1);
      q = (t - 1) % (PLANE_BITS + 1);
      if (q < PLANE_BITS) begin
        b = PLANE_BITS - 1 - q;
        for (int d = 0; d < NB_DRIVERS; d++) e_sout[d] = model_slice[d][PLANE_BITS * p + b];
        e_sclk = 1;
        e_lat = (p == NB_PLANES - 1) ? (b < LATGS_LEN) : (b < WRTGS_LEN);
      end else begin
        e_fd = (p == NB_PLANES - 1);
      end
    end
    check_val("data_ready", 32'(data_ready), 32'(e_ready));
    check_val("sout",       32'(sout),       32'(e_sout));
    check_val("sclk_en",    32'(sclk_en),    32'(e_sclk));
    check_val("lat",        32'(lat),        32'(e_lat));
    check_val("busy",       32'(busy),       32'(e_busy));
    check_val("frame_done", 32'(frame_done), 32'(e_fd));
  endtask

  task automatic rand_din();
    for (int d = 0; d < NB_DRIVERS; d++) begin
      for (int w = 0; w < 13; w++) din[d][w*32 +: 32] = $urandom();
      din[d][SLICE_BITS-1:416] = 16'($urandom());
    end
  endtask

  task automatic zero_din();
    for (int d = 0; d < NB_DRIVERS; d++) din[d] = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    zero_din();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    idle(2);

    // Single bit: driver 0, plane 0, bit 0.
    din[0][0] = 1'b1;
    step(1'b1, 1'b0);
    zero_din();
    idle(FRAME_LEN + 4);

    // All ones: SCLK/LAT cadence.
    for (int d = 0; d < NB_DRIVERS; d++) din[d] = '1;
    step(1'b1, 1'b0);
    idle(FRAME_LEN + 4);

    // Valid held high with data changing every cycle.
    for (int i = 0; i < 2 * (FRAME_LEN + 1) + 20; i++) begin
      rand_din();
      step(1'b1, 1'b0);
    end
    idle(FRAME_LEN + 4);

    // Reset in the middle of plane 4, bit 20.
    rand_din();
    step(1'b1, 1'b0);
    for (int i = 0; i < FRAME_LEN && t != 4 * (PLANE_BITS + 1) + (PLANE_BITS - 20); i++) begin
      rand_din();
      step(1'b0, 1'b0);
    end
    check_val("reach_p4_b20", 32'(t), 32'(4 * (PLANE_BITS + 1) + (PLANE_BITS - 20)));
    $display("mid-frame reset at cycle %0d", cyc);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);

    // Driver 14, plane 8, bit 47.
    zero_din();
    din[14][PLANE_BITS * 8 + 47] = 1'b1;
    step(1'b1, 1'b0);
    zero_din();
    idle(FRAME_LEN + 4);

`ifdef SOUT_TEST_PATTERN_EN
    rand_din();
    test_mode = 1'b1;
    step(1'b1, 1'b0);
    test_mode = 1'b0;
    idle(FRAME_LEN + 4);
`endif

    // Random slices with sparse valid.
    for (int i = 0; i < 2 * (FRAME_LEN + 1) + 50; i++) begin
      rand_din();
      step(1'($urandom_range(0, 3) == 0), 1'b0);
    end
    idle(FRAME_LEN + 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
